// File: rtl/stopwatch_core_if.sv
// Control pulses and display outputs of the stopwatch core.
// The master side (controller or bench) drives the pulses; the core (slave) drives the display.
interface stopwatch_core_if #(
  parameter int DIGITS = 4
);
  logic                  start_stop;
  logic                  lap;
  logic                  clear;
  logic [4*DIGITS-1:0]   disp;
  logic                  running;
  logic                  lap_active;
  logic                  overflow;
  logic                  tick;

  modport master (
    output start_stop, lap, clear,
    input  disp, running, lap_active, overflow, tick
  );

  modport slave (
    input  start_stop, lap, clear,
    output disp, running, lap_active, overflow, tick
  );
endinterface

// File: rtl/stopwatch_core.sv
// BCD stopwatch: prescaled decimal counter with run/pause/lap control,
// lap freeze register, sticky overflow and a registered tick pulse.
// Every output comes straight from a flop, so there is no input-to-output path.
module stopwatch_core #(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 100000,
  parameter bit SATURATE = 1'b0
) (
  input logic             clk,
  input logic             rst_n,
  stopwatch_core_if.slave bus
);

  localparam int            CW        = 4 * DIGITS;
  localparam int            PW        = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    LAP   = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   lap_q,   lap_d;
  logic            ovf_q,   ovf_d;
  logic [CW-1:0]   disp_q;
  logic            running_q;
  logic            lap_active_q;
  logic            tick_q;

  logic            inc;
  logic            all_nines;
  logic [CW-1:0]   count_inc;

  // Detect terminal count: every digit holds 9.
  always_comb begin
    all_nines = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (count_q[4*i +: 4] != 4'd9) all_nines = 1'b0;
    end
  end

  // Decimal +1 with ripple carry; a digit at 9 wraps to 0 and passes the carry on.
  always_comb begin
    logic carry;
    count_inc = count_q;
    carry     = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (count_q[4*i +: 4] == 4'd9) begin
          count_inc[4*i +: 4] = 4'd0;
        end else begin
          count_inc[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
          carry               = 1'b0;
        end
      end
    end
  end

  // Next-state: prescaler and count update first, then the control pulses
  // (clear > start_stop > lap) decide the state, so a tick on a pause or lap
  // edge is already contained in the paused or captured value.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned;
    // a missing default here would infer a latch.
    state_d = state_q;
    presc_d = presc_q;
    count_d = count_q;
    lap_d   = lap_q;
    ovf_d   = ovf_q;
    inc     = 1'b0;

    if (state_q == RUN || state_q == LAP) begin
      if (presc_q == PRESC_MAX) begin
        presc_d = '0;
        inc     = 1'b1;
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end

    if (inc) begin
      if (all_nines) ovf_d = 1'b1;
      if (!(all_nines && SATURATE)) count_d = count_inc;
    end

    unique case (state_q)
      IDLE: begin
        presc_d = '0;
        if (bus.start_stop) state_d = RUN;
      end
      RUN: begin
        if (bus.start_stop) begin
          state_d = PAUSE;
        end else if (bus.lap) begin
          state_d = LAP;
          lap_d   = count_d;
        end
      end
      PAUSE: begin
        if (bus.start_stop) state_d = RUN;
      end
      LAP: begin
        if (bus.start_stop)   state_d = PAUSE;
        else if (bus.lap)     state_d = RUN;
      end
      default: state_d = IDLE;
    endcase

    if (bus.clear) begin
      state_d = IDLE;
      presc_d = '0;
      count_d = '0;
      lap_d   = '0;
      ovf_d   = 1'b0;
    end
  end

  // State, counters and registered outputs; outputs are computed from next-state
  // so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      presc_q      <= '0;
      count_q      <= '0;
      // NOTE: the lap register is reset like any other state so that a reset
      // during LAP cannot leave a stale frozen value behind.
      lap_q        <= '0;
      ovf_q        <= 1'b0;
      disp_q       <= '0;
      running_q    <= 1'b0;
      lap_active_q <= 1'b0;
      tick_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q      <= state_d;
      presc_q      <= presc_d;
      count_q      <= count_d;
      lap_q        <= lap_d;
      ovf_q        <= ovf_d;
      disp_q       <= (state_d == LAP) ? lap_d : count_d;
      running_q    <= (state_d == RUN) || (state_d == LAP);
      lap_active_q <= (state_d == LAP);
      tick_q       <= ((state_d == RUN) || (state_d == LAP)) && (presc_d == PRESC_MAX);
    end
  end

  assign bus.disp       = disp_q;
  assign bus.running    = running_q;
  assign bus.lap_active = lap_active_q;
  assign bus.overflow   = ovf_q;
  assign bus.tick       = tick_q;

endmodule
